// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial add/sub sequencer.
// FSM state encoding and operation codes.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake bundle for serial_add_ctrl.
// master: decode/writeback side; slave: the sequencer.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, op_a, op_b, op_sub,
    output out_ready,
    input  in_ready, out_valid,
    input  result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub,
    input  out_ready,
    output in_ready, out_valid,
    output result, cout, ovf, zero
  );

endinterface

// File: rtl/fa_bit_cell.sv
// Combinational 1-bit full adder.
// Ports: a, b, c in; s = a^b^c, co = majority(a,b,c).
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/sub sequencer, LSB first, one shared FA cell.
// Ports: clk, rst_n (async low), bus (serial_add_ctrl_if.slave).
// Optional subtract support via `define SERIAL_SUB_EN.
module serial_add_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
  logic             carry_q;
  logic             cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             cell_s, cell_c;
  logic             last;

`ifdef SERIAL_SUB_EN
  assign b_in = bus.op_sub ? ~bus.op_b : bus.op_b;
  assign c_in = bus.op_sub;
`else
  logic unused_sub;
  assign unused_sub = bus.op_sub;
  assign b_in = bus.op_b;
  assign c_in = OP_ADD;
`endif

  fa_bit_cell u_cell (
    .a  (a_q[cnt_q]),
    .b  (b_q[cnt_q]),
    .c  (carry_q),
    .s  (cell_s),
    .co (cell_c)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  // Result with the current bit merged in, so the
  // zero flag sees the MSB on the final RUN edge.
  always_comb begin
    res_nxt        = res_q;
    res_nxt[cnt_q] = cell_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last)          state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.op_a;
            b_q     <= b_in;
            carry_q <= c_in;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          res_q   <= res_nxt;
          carry_q <= cell_c;
          if (last) begin
            // carry_q here is the carry into the MSB.
            cnt_q  <= '0;
            cout_q <= cell_c;
            ovf_q  <= carry_q ^ cell_c;
            zero_q <= (res_nxt == '0);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
